// File: rtl/mem_pkg.sv
// mem_pkg: shared types and derived-width helpers for the line_memory block.
//   mem_state_e     - transaction FSM states (IDLE, BUSY, RESP)
//   words_per_line  - words carried by one fill line
//   off_w / idx_w   - word-offset-in-line and word-index address widths
//   cnt_w           - width of the latency down-counter
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    function automatic int words_per_line(input int fill_w, input int store_w);
        return fill_w / store_w;
    endfunction

    function automatic int off_w(input int fill_w, input int store_w);
        return $clog2(fill_w / store_w);
    endfunction

    function automatic int idx_w(input int spaces);
        return $clog2(spaces);
    endfunction

    // Counter only ever holds LATENCY-2 down to 0; keep at least one bit.
    function automatic int cnt_w(input int latency);
        return (latency > 2) ? $clog2(latency - 1) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// mem_array: word-addressed flop storage for line_memory.
//   clk, reset_n  - clock, async active-low reset (clears all words)
//   wr_en         - commit a byte-masked write of wr_data to word wr_idx
//   wr_idx        - word index
//   wr_data/wr_be - store word and its byte mask
//   rd_line       - line index for the combinational read port
//   rd_data       - the addressed line, word i at [(i+1)*SW-1 : i*SW]
module mem_array
    import mem_pkg::*;
#(
    parameter int FILL_DATA_WIDTH  = 128,
    parameter int STORE_DATA_WIDTH = 32,
    parameter int SPACES           = 128,
    localparam int WPL    = words_per_line(FILL_DATA_WIDTH, STORE_DATA_WIDTH),
    localparam int IDX_W  = idx_w(SPACES),
    localparam int LINE_W = idx_w(SPACES) - off_w(FILL_DATA_WIDTH, STORE_DATA_WIDTH),
    localparam int BE_W   = STORE_DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [STORE_DATA_WIDTH-1:0] wr_data,
    input  logic [BE_W-1:0]             wr_be,
    input  logic [LINE_W-1:0]           rd_line,
    output logic [FILL_DATA_WIDTH-1:0]  rd_data
);

    logic [SPACES-1:0][STORE_DATA_WIDTH-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (wr_be[b]) begin
                    mem_d[wr_idx][b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read from the write-merged view so a store's response line already
    // holds the new bytes; loads never write, so this equals mem_q for them.
    always_comb begin
        rd_data = '0;
        for (int w = 0; w < WPL; w++) begin
            rd_data[w*STORE_DATA_WIDTH +: STORE_DATA_WIDTH] =
                mem_d[IDX_W'(int'(rd_line) * WPL + w)];
        end
    end

endmodule

// File: rtl/line_memory.sv
// line_memory: main-memory model behind a cache port. Line loads, byte-masked
// word stores, one outstanding transaction, fixed LATENCY to the response.
//   clk, reset_n    - clock, async active-low reset (state and contents)
//   req/req_ready   - request handshake; accept on req & req_ready
//   store           - 1 word store, 0 line load
//   address         - word address (bits above the array size ignored)
//   evict_data      - store word; byte_en its byte mask
//   response_valid  - one-cycle pulse LATENCY cycles after accept
//   response_store  - type of the answered transaction
//   fill_data       - line data (post-write line for stores)
module line_memory
    import mem_pkg::*;
#(
    parameter int FILL_DATA_WIDTH  = 128,
    parameter int STORE_DATA_WIDTH = 32,
    parameter int SPACES           = 128,
    parameter int ADDRESS_WIDTH    = 32,
    parameter int LATENCY          = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          req,
    input  logic                          store,
    input  logic [ADDRESS_WIDTH-1:0]      address,
    input  logic [STORE_DATA_WIDTH-1:0]   evict_data,
    input  logic [STORE_DATA_WIDTH/8-1:0] byte_en,
    output logic                          req_ready,
    output logic                          response_valid,
    output logic                          response_store,
    output logic [FILL_DATA_WIDTH-1:0]    fill_data
);

    localparam int WPL    = words_per_line(FILL_DATA_WIDTH, STORE_DATA_WIDTH);
    localparam int OFF_W  = off_w(FILL_DATA_WIDTH, STORE_DATA_WIDTH);
    localparam int IDX_W  = idx_w(SPACES);
    localparam int LINE_W = IDX_W - OFF_W;
    localparam int CNT_W  = cnt_w(LATENCY);

    if (FILL_DATA_WIDTH % STORE_DATA_WIDTH != 0) begin : g_chk_fill
        $error("FILL_DATA_WIDTH must be a multiple of STORE_DATA_WIDTH");
    end
    if (SPACES % WPL != 0) begin : g_chk_spaces
        $error("SPACES must be a multiple of WORDS_PER_LINE");
    end
    if ((SPACES & (SPACES - 1)) != 0) begin : g_chk_pow2
        $error("SPACES must be a power of 2");
    end
    if (STORE_DATA_WIDTH % 8 != 0) begin : g_chk_bytes
        $error("STORE_DATA_WIDTH must be a multiple of 8");
    end
    if (LATENCY < 1) begin : g_chk_lat
        $error("LATENCY must be at least 1");
    end

    mem_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       valid_q, valid_d;
    logic                       store_q, store_d;
    logic [FILL_DATA_WIDTH-1:0] fill_q, fill_d;

    logic                       accept;
    logic                       wr_en;
    logic [IDX_W-1:0]           word_idx;
    logic [LINE_W-1:0]          line_idx;
    logic [FILL_DATA_WIDTH-1:0] line_rd;

    // Upper address bits wrap away; tie them off explicitly.
    if (ADDRESS_WIDTH > IDX_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^address[ADDRESS_WIDTH-1:IDX_W];
    end

    assign word_idx  = address[IDX_W-1:0];
    assign line_idx  = word_idx[IDX_W-1:OFF_W];

    // Ready depends only on state (and reset), never on req.
    assign req_ready = reset_n && (state_q == IDLE || state_q == RESP);
    assign accept    = req && req_ready;
    assign wr_en     = accept && store;

    mem_array #(
        .FILL_DATA_WIDTH  (FILL_DATA_WIDTH),
        .STORE_DATA_WIDTH (STORE_DATA_WIDTH),
        .SPACES           (SPACES)
    ) u_array (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_idx  (word_idx),
        .wr_data (evict_data),
        .wr_be   (byte_en),
        .rd_line (line_idx),
        .rd_data (line_rd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        fill_d  = fill_q;

        case (state_q)
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (!accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared accept path for IDLE and RESP (back-to-back).
        if (accept) begin
            store_d = store;
            fill_d  = line_rd;
            if (LATENCY == 1) begin
                state_d = RESP;
            end else begin
                state_d = BUSY;
                cnt_d   = CNT_W'(LATENCY - 2);
            end
        end

        valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            store_q <= 1'b0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            store_q <= store_d;
            fill_q  <= fill_d;
        end
    end

    assign response_valid = valid_q;
    assign response_store = store_q;
    assign fill_data      = fill_q;

endmodule

// File: tb/tb_line_memory.sv
module tb_line_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // DUT A: default parameters (LATENCY 5), scoreboard checked
    logic         a_req, a_store;
    logic [31:0]  a_addr, a_data;
    logic [3:0]   a_be;
    logic         a_ready, a_rv, a_rs;
    logic [127:0] a_fill;

    // DUT B: LATENCY 1, checked inline
    logic         b_req, b_store;
    logic [31:0]  b_addr, b_data;
    logic [3:0]   b_be;
    logic         b_ready, b_rv, b_rs;
    logic [127:0] b_fill;

    line_memory u_a (
        .clk(clk), .reset_n(reset_n), .req(a_req), .store(a_store),
        .address(a_addr), .evict_data(a_data), .byte_en(a_be),
        .req_ready(a_ready), .response_valid(a_rv),
        .response_store(a_rs), .fill_data(a_fill)
    );

    line_memory #(.LATENCY(1)) u_b (
        .clk(clk), .reset_n(reset_n), .req(b_req), .store(b_store),
        .address(b_addr), .evict_data(b_data), .byte_en(b_be),
        .req_ready(b_ready), .response_valid(b_rv),
        .response_store(b_rs), .fill_data(b_fill)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         st;
        logic [127:0] line;
    } exp_t;

    exp_t         sb[$];
    exp_t         a_exp;
    logic [31:0]  model[128];
    logic [127:0] last_fill;

    function automatic logic [127:0] model_line(input logic [31:0] addr);
        logic [127:0] l;
        logic [6:0]   base;
        base = {addr[6:2], 2'b00};
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = model[base + 7'(i)];
        return l;
    endfunction

    // Reference: apply accepted stores and queue the expected response.
    always @(posedge clk) begin
        if (reset_n && a_req && a_ready) begin
            if (a_store) begin
                for (int b = 0; b < 4; b++)
                    if (a_be[b]) model[a_addr[6:0]][b*8 +: 8] = a_data[b*8 +: 8];
            end
            sb.push_back({a_store, model_line(a_addr)});
        end
    end

    // Response monitor for DUT A.
    always @(negedge clk) begin
        if (a_rv) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_resp: response_valid with nothing outstanding, fill=%h", a_fill);
            end else begin
                a_exp = sb.pop_front();
                if (a_rs !== a_exp.st || a_fill !== a_exp.line) begin
                    errors++;
                    $display("FAIL a_resp: got store=%0b fill=%h, want store=%0b fill=%h",
                             a_rs, a_fill, a_exp.st, a_exp.line);
                end
                last_fill = a_fill;
            end
        end
    end

    task automatic issue(input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        int n;
        @(negedge clk);
        a_req = 1'b1; a_store = st; a_addr = addr; a_data = data; a_be = be;
        n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL issue_timeout: req_ready=%0b after %0d cycles, want 1", a_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb.size());
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0 || a_rv !== 1'b0 || a_rs !== 1'b0 || a_fill !== '0) begin
            errors++;
            $display("FAIL reset_state: ready=%0b/%0b rv=%0b rs=%0b fill=%h, want 0/0 0 0 0",
                     a_ready, b_ready, a_rv, a_rs, a_fill);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%0b/%0b, want 1/1", a_ready, b_ready);
        end
    endtask

    task automatic test_load_latency();
        logic ok;
        last_fill = '1;
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (a_ready !== 1'b0 || a_rv !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_window: ready/valid not low for 4 cycles after accept");
        end
        checks++;
        if (a_rv !== 1'b1 || a_ready !== 1'b1) begin
            errors++;
            $display("FAIL resp_latency: rv=%0b ready=%0b at accept+5, want 1 1", a_rv, a_ready);
        end
        wait_drain();
        checks++;
        if (last_fill !== '0) begin
            errors++;
            $display("FAIL load_zero: fill=%h, want 0", last_fill);
        end
    endtask

    task automatic test_store_full();
        issue(1'b1, 32'h21, 32'hDEADBEEF, 4'b1111);
        last_fill = '1;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_drain();
        checks++;
        if (last_fill !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin
            errors++;
            $display("FAIL store_full: fill=%h, want word1=deadbeef others 0", last_fill);
        end
    endtask

    task automatic test_store_mask();
        issue(1'b1, 32'h21, 32'h11223344, 4'b0101);
        last_fill = '1;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        wait_drain();
        checks++;
        if (last_fill[63:32] !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL store_mask: word1=%h, want de22be44", last_fill[63:32]);
        end
    endtask

    task automatic test_back_to_back();
        int  rdy, vld;
        logic coin;
        @(negedge clk);
        a_req = 1'b1; a_store = 1'b0; a_addr = 32'h20; a_data = '0; a_be = '0;
        rdy = 0; vld = 0; coin = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (a_ready) rdy++;
            if (a_rv) begin
                vld++;
                if (!a_ready) coin = 1'b0;
            end
            @(negedge clk);
        end
        a_req = 1'b0;
        checks++;
        if (rdy != 4 || vld != 3 || !coin) begin
            errors++;
            $display("FAIL b2b_lat5: accepts=%0d responses=%0d coincide=%0b, want 4 3 1", rdy, vld, coin);
        end
        wait_drain();
    endtask

    task automatic test_lat1_pipeline();
        logic ok_rdy, ok_rsp;
        @(negedge clk);
        b_req = 1'b1; b_store = 1'b1; b_addr = 32'h0; b_data = 32'hA5A5A5A5; b_be = 4'hF;
        ok_rdy = 1'b1; ok_rsp = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (b_ready !== 1'b1) ok_rdy = 1'b0;
            if (n == 0) begin
                if (b_rv !== 1'b0) ok_rsp = 1'b0;
            end else if (b_rv !== 1'b1 || b_rs !== (n == 1) ||
                         b_fill !== {96'h0, 32'hA5A5A5A5}) begin
                ok_rsp = 1'b0;
            end
            @(negedge clk);
            b_store = 1'b0;
        end
        b_req = 1'b0;
        checks++;
        if (!ok_rdy) begin
            errors++;
            $display("FAIL lat1_ready: req_ready dropped while req held, want 1 every cycle");
        end
        checks++;
        if (!ok_rsp) begin
            errors++;
            $display("FAIL lat1_resp: per-cycle response mismatch, last rv=%0b rs=%0b fill=%h",
                     b_rv, b_rs, b_fill);
        end
        checks++;
        if (b_rv !== 1'b1) begin
            errors++;
            $display("FAIL lat1_last: rv=%0b for final accept, want 1", b_rv);
        end
        @(negedge clk);
        checks++;
        if (b_rv !== 1'b0) begin
            errors++;
            $display("FAIL lat1_idle: rv=%0b after req dropped, want 0", b_rv);
        end
    endtask

    task automatic test_wrap();
        issue(1'b1, 32'h01, 32'hCAFEF00D, 4'hF);
        last_fill = '1;
        issue(1'b0, 32'h80, 32'h0, 4'h0);
        wait_drain();
        checks++;
        if (last_fill !== {32'h0, 32'h0, 32'hCAFEF00D, 32'h0}) begin
            errors++;
            $display("FAIL addr_wrap: fill=%h, want line 0 with word1=cafef00d", last_fill);
        end
    endtask

    task automatic test_reset_abort();
        int spurious;
        issue(1'b1, 32'h05, 32'h12345678, 4'hF);
        @(negedge clk);
        #2 reset_n = 1'b0;
        sb.delete();
        for (int i = 0; i < 128; i++) model[i] = '0;
        #1;
        checks++;
        if (a_rv !== 1'b0 || a_fill !== '0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: rv=%0b fill=%h ready=%0b, want 0 0 0", a_rv, a_fill, a_ready);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_rv) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL abort_noresp: %0d responses after reset, want 0", spurious);
        end
        last_fill = '1;
        issue(1'b0, 32'h04, 32'h0, 4'h0);
        wait_drain();
        checks++;
        if (last_fill !== '0) begin
            errors++;
            $display("FAIL abort_cleared: fill=%h, want 0", last_fill);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) model[i] = '0;
        last_fill = '0;
        a_req = 0; a_store = 0; a_addr = '0; a_data = '0; a_be = '0;
        b_req = 0; b_store = 0; b_addr = '0; b_data = '0; b_be = '0;
        test_reset();
        test_load_latency();
        test_store_full();
        test_store_mask();
        test_back_to_back();
        test_lat1_pipeline();
        test_wrap();
        test_reset_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: %0d expected responses never arrived, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
